ddr_line_fetch: RTL and testbench

- Fetches one 512-pixel background scanline per video line from DDR into a ping-pong line buffer.
- Supplies 24-bit RGB pixels to the video output stage, indexed by the video generator's hcnt/vcnt.
- Sits directly upstream of the RGB path driven by video_gen.
- Single clock domain; the pixel rate is set by a ce_pix enable.

---
 rtl/ddr_line_fetch_pkg.sv | 30 +++
 rtl/ddr_line_fetch_if.sv | 22 ++
 rtl/ddr_line_fetch_buf.sv | 23 ++
 rtl/ddr_line_fetch.sv | 166 ++++++++++++++++
 tb/tb_ddr_line_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ddr_line_fetch_pkg.sv
// Shared types and constants for the DDR background line fetcher.
package ddr_line_pkg;

    localparam int DDR_DW = 64;
    localparam int DDR_AW = 29;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Stored pixels are {pad8, R, G, B}; the pad byte carries nothing.
    function automatic rgb_t unpack_pixel(input logic [31:0] px);
        rgb_t       c;
        logic [7:0] pad_unused;
        pad_unused = px[31:24];
        c.r = px[23:16];
        c.g = px[15:8];
        c.b = px[7:0];
        return c;
    endfunction

endpackage

// File: rtl/ddr_line_fetch_if.sv
// DDR read-port bundle between the line fetcher (master) and the memory (slave).
interface ddr_line_fetch_if;
    import ddr_line_pkg::*;

    logic              ddr_busy;
    logic [7:0]        ddr_burstcnt;
    logic [DDR_AW-1:0] ddr_addr;
    logic              ddr_rd;
    logic [DDR_DW-1:0] ddr_dout;
    logic              ddr_dout_ready;

    modport master (
        input  ddr_busy, ddr_dout, ddr_dout_ready,
        output ddr_burstcnt, ddr_addr, ddr_rd
    );

    modport slave (
        output ddr_busy, ddr_dout, ddr_dout_ready,
        input  ddr_burstcnt, ddr_addr, ddr_rd
    );

endinterface

// File: rtl/ddr_line_fetch_buf.sv
// Two-bank ping-pong line store: one write port, one registered read port.
module line_buffer_dp
    import ddr_line_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DDR_DW-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DDR_DW-1:0] o_rdata
);

    logic [DDR_DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ddr_line_fetch.sv
// Fetches the next background scanline from DDR during hblank into the back bank
// of a ping-pong buffer and streams the front bank out as RGB.
module ddr_line_fetch
    import ddr_line_pkg::*;
#(
    parameter logic [DDR_AW-1:0] BASE_ADDR  = 29'h0C00_0000,
    parameter int                LINE_WORDS = 256,
    parameter int                BURST      = 128,
    parameter int                V_LINES    = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    input  logic             hblank,
    input  logic             vblank,
    input  logic             de,
    ddr_line_fetch_if.master ddr,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             underflow
);

    localparam int          NBURST   = LINE_WORDS / BURST;
    localparam int          WIDX_W   = $clog2(LINE_WORDS);
    localparam int          BEAT_W   = $clog2(BURST);
    localparam int          BIDX_W   = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam logic [9:0]  H_ACTIVE = 10'(2 * LINE_WORDS);

    fetch_state_t      r_state, w_next;
    logic              r_hblank_d, r_rd, r_fetch_done, r_blank_fetch, r_blank_disp;
    logic              r_disp_bank, r_abort, r_underflow;
    logic [DDR_AW-1:0] r_addr;
    logic [9:0]        r_line;
    logic [WIDX_W-1:0] r_widx;
    logic [BEAT_W-1:0] r_beat;
    logic [BIDX_W-1:0] r_burst;
    logic              r_hsel, r_de_d, r_black_d;
    rgb_t              r_rgb;

    logic              w_trig, w_fall, w_yn_blank, w_beat_last, w_burst_last, w_abort_now, w_we;
    logic [9:0]        w_yn, w_line_sel;
    logic [BIDX_W-1:0] w_burst_sel;
    logic [DDR_AW-1:0] w_req_addr;
    logic [DDR_DW-1:0] w_rdata;
    logic [31:0]       w_pix;

    assign w_trig       = hblank & ~r_hblank_d;
    assign w_fall       = ~hblank & r_hblank_d;
    assign w_yn         = vblank ? '0 : vcnt + 10'd1;
    assign w_yn_blank   = (w_yn >= 10'(V_LINES));
    assign w_beat_last  = (r_beat == BEAT_W'(BURST - 1));
    assign w_burst_last = (r_burst == BIDX_W'(NBURST - 1));
    assign w_abort_now  = r_abort | (w_fall & ~r_fetch_done);
    assign w_we         = (r_state == DATA) & ddr.ddr_dout_ready;

    // A new request comes either from IDLE (fresh line, burst 0) or from DATA (next burst).
    assign w_line_sel  = (r_state == IDLE) ? w_yn : r_line;
    assign w_burst_sel = (r_state == IDLE) ? '0 : r_burst + 1'b1;
    assign w_req_addr  = BASE_ADDR + DDR_AW'(w_line_sel) * DDR_AW'(LINE_WORDS)
                       + DDR_AW'(w_burst_sel) * DDR_AW'(BURST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_trig && !w_yn_blank) w_next = REQ;
            REQ:  if (!ddr.ddr_busy) w_next = DATA;
            DATA: if (ddr.ddr_dout_ready && w_beat_last)
                      w_next = (w_burst_last || w_abort_now) ? IDLE : REQ;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hblank_d    <= 1'b0;
            r_rd          <= 1'b0;
            r_addr        <= '0;
            r_line        <= '0;
            r_widx        <= '0;
            r_beat        <= '0;
            r_burst       <= '0;
            r_fetch_done  <= 1'b0;
            r_blank_fetch <= 1'b0;
            r_blank_disp  <= 1'b0;
            r_disp_bank   <= 1'b0;
            r_abort       <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_hblank_d <= hblank;
            if (r_state == IDLE && w_trig) begin
                r_line        <= w_yn;
                r_widx        <= '0;
                r_beat        <= '0;
                r_burst       <= '0;
                r_fetch_done  <= w_yn_blank;
                r_blank_fetch <= w_yn_blank;
            end
            if (w_we) begin
                r_widx <= r_widx + 1'b1;
                r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                if (w_beat_last) begin
                    r_burst <= r_burst + 1'b1;
                    if (w_burst_last && !w_abort_now) r_fetch_done <= 1'b1;
                end
            end
            // Late line: keep showing the old bank and let the current burst drain.
            if (w_fall) begin
                if (r_fetch_done) begin
                    r_disp_bank  <= ~r_disp_bank;
                    r_blank_disp <= r_blank_fetch;
                end else begin
                    r_underflow <= 1'b1;
                    if (r_state != IDLE) r_abort <= 1'b1;
                end
            end
            if (w_next == IDLE) r_abort <= 1'b0;
            r_rd <= (w_next == REQ);
            if (w_next == REQ && r_state != REQ) r_addr <= w_req_addr;
        end
    end

    line_buffer_dp #(
        .DEPTH (2 * LINE_WORDS),
        .AW    (WIDX_W + 1)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({~r_disp_bank, r_widx}),
        .i_wdata (ddr.ddr_dout),
        .i_raddr ({r_disp_bank, hcnt[WIDX_W:1]}),
        .o_rdata (w_rdata)
    );

    assign w_pix = r_hsel ? w_rdata[63:32] : w_rdata[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsel    <= 1'b0;
            r_de_d    <= 1'b0;
            r_black_d <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_hsel    <= hcnt[0];
            r_de_d    <= de;
            r_black_d <= (hcnt >= H_ACTIVE) | r_blank_disp;
            if (ce_pix) r_rgb <= (r_de_d && !r_black_d) ? unpack_pixel(w_pix) : '0;
        end
    end

    assign ddr.ddr_rd       = r_rd;
    assign ddr.ddr_addr     = r_addr;
    assign ddr.ddr_burstcnt = 8'(BURST);
    assign r                = r_rgb.r;
    assign g                = r_rgb.g;
    assign b                = r_rgb.b;
    assign underflow        = r_underflow;

endmodule

// File: tb/tb_ddr_line_fetch.sv
// Directed self-checking bench for ddr_line_fetch: fetch addressing, busy hold,
// pixel readout, underflow, blank lines, vblank line 0 and async reset.
module tb_ddr_line_fetch;

    localparam logic [28:0] BASE = 29'h0C00_0000;

    logic       clk;
    logic       rst_n;
    logic       ce_pix;
    logic [9:0] hcnt, vcnt;
    logic       hblank, vblank, de;
    logic [7:0] r, g, b;
    logic       underflow;
    int         n_checks;
    int         n_fail;
    int         n_acc;

    ddr_line_fetch_if ifc ();

    ddr_line_fetch #(
        .BASE_ADDR  (29'h0C00_0000),
        .LINE_WORDS (256),
        .BURST      (128),
        .V_LINES    (512)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .ce_pix    (ce_pix),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hblank    (hblank),
        .vblank    (vblank),
        .de        (de),
        .ddr       (ifc),
        .r         (r),
        .g         (g),
        .b         (b),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests the memory side has accepted (rd high, busy low at a rising edge).
    initial n_acc = 0;
    always @(posedge clk) if (ifc.ddr_rd === 1'b1 && ifc.ddr_busy === 1'b0) n_acc++;

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_burst(input int k0, input logic [31:0] add);
        for (int i = 0; i < 128; i++) begin
            ifc.ddr_dout       = {add + 32'(2 * (k0 + i) + 1), add + 32'(2 * (k0 + i))};
            ifc.ddr_dout_ready = 1'b1;
            tick();
        end
        ifc.ddr_dout_ready = 1'b0;
    endtask

    task automatic show_pixel(input int x, input logic [23:0] exp, input string tag);
        hcnt = 10'(x);
        tick();
        tick();
        check(tag, {r, g, b}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; ce_pix = 1'b1; hcnt = '0; vcnt = '0;
        hblank = 1'b0; vblank = 1'b0; de = 1'b0;
        ifc.ddr_busy = 1'b0; ifc.ddr_dout = '0; ifc.ddr_dout_ready = 1'b0;
        repeat (3) tick();
        check("rst_rd", ifc.ddr_rd, 0);
        check("rst_addr", ifc.ddr_addr, 0);
        check("rst_burstcnt", ifc.ddr_burstcnt, 128);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_underflow", underflow, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Line 10 fetch: two bursts at BASE+2560 and BASE+2688.
        vcnt = 10'd9; hblank = 1'b1;
        tick();
        check("req0_rd", ifc.ddr_rd, 1);
        check("req0_addr", ifc.ddr_addr, BASE + 29'd2560);
        check("req0_burstcnt", ifc.ddr_burstcnt, 128);
        tick();
        check("req0_drop", ifc.ddr_rd, 0);
        ifc.ddr_busy = 1'b1;
        send_burst(0, 32'h0);
        for (int j = 0; j < 5; j++) begin
            check("busy_rd", ifc.ddr_rd, 1);
            check("busy_addr", ifc.ddr_addr, BASE + 29'd2688);
            tick();
        end
        ifc.ddr_busy = 1'b0;
        tick();
        check("req1_drop", ifc.ddr_rd, 0);
        check("acc_after_busy", n_acc, 2);
        send_burst(128, 32'h0);
        tick();
        check("line_done_idle", ifc.ddr_rd, 0);
        check("acc_line10", n_acc, 2);

        // Swap and sweep the whole line.
        hblank = 1'b0; de = 1'b1;
        tick();
        for (int i = 0; i <= 512; i++) begin
            hcnt = 10'(i);
            tick();
            if (i >= 1) check("sweep_px", {r, g, b}, 24'(i - 1));
        end
        show_pixel(600, 24'h0, "hcnt_ge_512");
        de = 1'b0;
        show_pixel(9, 24'h0, "de_low_black");
        de = 1'b1;
        show_pixel(7, 24'd7, "px7");
        ce_pix = 1'b0; hcnt = 10'd20;
        repeat (3) tick();
        check("ce_hold", {r, g, b}, 24'd7);
        ce_pix = 1'b1;
        tick();
        check("ce_update", {r, g, b}, 24'd20);

        // Late line 11: no data before hblank falls.
        vcnt = 10'd10; hblank = 1'b1;
        tick();
        check("req_l11_addr", ifc.ddr_addr, BASE + 29'd2816);
        tick();
        check("acc_l11", n_acc, 3);
        repeat (3) tick();
        hblank = 1'b0;
        tick();
        check("underflow_set", underflow, 1);
        show_pixel(3, 24'd3, "repeat_px3");
        show_pixel(300, 24'd300, "repeat_px300");
        send_burst(0, 32'h00A0_0000);
        repeat (4) tick();
        check("abort_no_req", ifc.ddr_rd, 0);
        check("abort_acc", n_acc, 3);
        show_pixel(100, 24'd100, "repeat_px100");

        // Next line 21 fetches normally after the aborted one.
        vcnt = 10'd20; hblank = 1'b1;
        tick();
        check("req_l21_rd", ifc.ddr_rd, 1);
        check("req_l21_addr", ifc.ddr_addr, BASE + 29'd5376);
        tick();
        send_burst(0, 32'h0080_0000);
        check("req_l21b_addr", ifc.ddr_addr, BASE + 29'd5504);
        tick();
        send_burst(128, 32'h0080_0000);
        hblank = 1'b0;
        tick();
        check("underflow_sticky", underflow, 1);
        show_pixel(0, 24'h80_0000, "l21_px0");
        show_pixel(511, 24'h80_01FF, "l21_px511");

        // Line 512 is past the background: no request, black output.
        vcnt = 10'd511; hblank = 1'b1;
        repeat (2) tick();
        check("blank_no_rd", ifc.ddr_rd, 0);
        check("blank_acc", n_acc, 5);
        hblank = 1'b0;
        tick();
        show_pixel(5, 24'h0, "blank_px5");

        // vblank targets line 0; reset lands while the request is stalled.
        vblank = 1'b1; vcnt = 10'd600; hblank = 1'b1; ifc.ddr_busy = 1'b1;
        tick();
        check("vblank_addr", ifc.ddr_addr, BASE);
        tick();
        check("vblank_rd_held", ifc.ddr_rd, 1);
        rst_n = 1'b0;
        #1;
        check("async_rd", ifc.ddr_rd, 0);
        check("async_addr", ifc.ddr_addr, 0);
        check("async_underflow", underflow, 0);
        check("async_rgb", {r, g, b}, 0);
        hblank = 1'b0; vblank = 1'b0; ifc.ddr_busy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rd", ifc.ddr_rd, 0);
        vcnt = 10'd9; hblank = 1'b1;
        tick();
        check("resume_rd", ifc.ddr_rd, 1);
        check("resume_addr", ifc.ddr_addr, BASE + 29'd2560);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
